// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Round-robin scheduler that shares one UART transmit line between N_REQ
//   byte requesters and serialises each granted byte as 8N1 / 8N2.
//   Packets (bytes up to and including one flagged last) are atomic: the
//   grant stays locked to one requester until its last byte has gone out,
//   unless that requester stays idle for LOCK_TO bit ticks.
//
// Ports
//   CLK        system clock
//   rst_n      asynchronous active-low reset
//   bit_tick   one-cycle strobe at 1x baud
//   req_valid  per-requester byte pending
//   req_data   byte of requester i in bits [8i+7:8i]
//   req_last   byte of requester i closes its packet
//   req_ready  registered one-hot accept pulse
//   tx         serial output, idle high
//   busy       high from LOAD entry until the frame returns to IDLE
//   grant_id   current or last granted requester
//   lock_err   one-cycle pulse when a packet lock times out
//   state_dbg  current FSM state, for observation only
//
// Handshake: a byte moves when req_valid[i] and req_ready[i] are both high
// in the same cycle. The requester keeps valid/data/last stable until then.
// req_ready is registered, one-hot, and high only during the LOAD cycle.

module uart_tx_sched #(
  parameter int N_REQ     = 4,
  parameter int STOP_BITS = 1,
  parameter int LOCK_TO   = 32,
  localparam int GW       = $clog2(N_REQ)
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               bit_tick,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx,
  output logic               busy,
  output logic [GW-1:0]      grant_id,
  output logic               lock_err,
  output logic [2:0]         state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SYNC  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  localparam int CW = $clog2(LOCK_TO + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  logic [2:0]    state;
  logic          locked;
  logic [GW-1:0] rr_ptr;
  logic [7:0]    shift;
  logic          last_q;
  logic [2:0]    bitcnt;
  logic          stop_cnt;
  logic [CW-1:0] lock_cnt;

  logic [GW-1:0] pick;
  logic [GW-1:0] ptr_after;
  int            idx;

  assign state_dbg = state;

  // First valid index at or above rr_ptr, wrapping. Scanning offsets from
  // high to low lets the smallest offset overwrite the others.
  always_comb begin
    pick = rr_ptr;
    idx  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) pick = GW'(idx);
    end
  end

  assign ptr_after = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      locked    <= 1'b0;
      rr_ptr    <= '0;
      shift     <= '0;
      last_q    <= 1'b0;
      bitcnt    <= '0;
      stop_cnt  <= 1'b0;
      lock_cnt  <= '0;
      req_ready <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      grant_id  <= '0;
      lock_err  <= 1'b0;
    end else begin
      lock_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!locked) begin
            lock_cnt <= '0;
            if (|req_valid) begin
              grant_id  <= pick;
              req_ready <= ONE_HOT0 << pick;
              busy      <= 1'b1;
              state     <= S_LOAD;
            end
          end else if (req_valid[grant_id]) begin
            lock_cnt  <= '0;
            req_ready <= ONE_HOT0 << grant_id;
            busy      <= 1'b1;
            state     <= S_LOAD;
          end else if (bit_tick) begin
            // Locked owner idle: give up the line on the LOCK_TO-th tick.
            if (lock_cnt == CW'(LOCK_TO - 1)) begin
              locked   <= 1'b0;
              lock_err <= 1'b1;
              rr_ptr   <= ptr_after;
              lock_cnt <= '0;
            end else begin
              lock_cnt <= lock_cnt + 1'b1;
            end
          end
        end
        S_LOAD: begin
          req_ready <= '0;
          shift     <= req_data[8*grant_id +: 8];
          last_q    <= req_last[grant_id];
          state     <= S_SYNC;
        end
        S_SYNC: begin
          if (bit_tick) begin
            tx    <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (bit_tick) begin
            tx     <= shift[0];
            bitcnt <= '0;
            state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            if (bitcnt == 3'd7) begin
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= S_STOP;
            end else begin
              shift  <= shift >> 1;
              tx     <= shift[1];
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              busy  <= 1'b0;
              state <= S_IDLE;
              if (last_q) begin
                locked <= 1'b0;
                rr_ptr <= ptr_after;
              end else begin
                locked <= 1'b1;
              end
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
//   Directed bench for uart_tx_sched. u_dut uses one stop bit and is fed by
//   per-requester byte queues; u_dut2 uses two stop bits and is driven
//   directly. bit_tick pulses every 4 CLKs.

module tb_uart_tx_sched;

  localparam int N = 4;

  logic           CLK;
  logic           rst_n;
  logic           bit_tick;

  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           tx, busy, lock_err;
  logic [1:0]     grant_id;
  logic [2:0]     state_dbg;

  logic [N-1:0]   req_valid2, req_last2, req_ready2;
  logic [8*N-1:0] req_data2;
  logic           tx2, busy2, lock_err2;
  logic [1:0]     grant_id2;
  logic [2:0]     state_dbg2;

  int errors;
  int checks;

  // Pending bytes per requester: {last, data}
  logic [8:0]   req_q [N][$];
  logic [N-1:0] accept_pend;

  uart_tx_sched #(.N_REQ(N), .STOP_BITS(1), .LOCK_TO(32)) u_dut (
    .CLK(CLK), .rst_n(rst_n), .bit_tick(bit_tick),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx(tx), .busy(busy), .grant_id(grant_id),
    .lock_err(lock_err), .state_dbg(state_dbg)
  );

  uart_tx_sched #(.N_REQ(N), .STOP_BITS(2), .LOCK_TO(32)) u_dut2 (
    .CLK(CLK), .rst_n(rst_n), .bit_tick(bit_tick),
    .req_valid(req_valid2), .req_data(req_data2), .req_last(req_last2),
    .req_ready(req_ready2), .tx(tx2), .busy(busy2), .grant_id(grant_id2),
    .lock_err(lock_err2), .state_dbg(state_dbg2)
  );

  // ---------------- clock / reset / tick ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin : tick_gen
    int ph;
    ph = 0;
    bit_tick = 1'b0;
    forever begin
      @(posedge CLK); #1;
      ph = (ph + 1) % 4;
      bit_tick = (ph == 0);
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- requester driver ----------------
  // Pops a byte the cycle after its accept, then presents the next one.
  initial begin : responder
    req_valid   = '0;
    req_data    = '0;
    req_last    = '0;
    accept_pend = '0;
    forever begin
      @(posedge CLK); #2;
      for (int i = 0; i < N; i++) begin
        if (accept_pend[i] && req_q[i].size() > 0) void'(req_q[i].pop_front());
        if (req_q[i].size() > 0) begin
          req_valid[i]      = 1'b1;
          req_data[8*i +: 8] = req_q[i][0][7:0];
          req_last[i]       = req_q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      accept_pend = req_valid & req_ready;
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_tx(input bit sel);
    return sel ? tx2 : tx;
  endfunction

  function automatic logic cur_busy(input bit sel);
    return sel ? busy2 : busy;
  endfunction

  task automatic wait_start(input bit sel, output int n);
    n = 0;
    while (cur_tx(sel) !== 1'b0 && n < 600) begin
      step();
      n++;
    end
    check("start_found", 32'(n < 600), 1);
  endtask

  // Waits for a start bit, then checks every CLK of start, 8 data bits
  // (LSB first) and nstop stop bits, each 4 CLKs long. gap<0 skips the
  // check on the number of cycles spent waiting for the start bit.
  task automatic frame(input bit sel, input logic [7:0] b, input logic [1:0] gid,
                       input int nstop, input int gap, input string tag);
    int   n;
    logic e;
    wait_start(sel, n);
    if (gap >= 0) check({tag, ".gap"}, n, gap);
    check({tag, ".gid"}, sel ? grant_id2 : grant_id, gid);
    check({tag, ".busy"}, cur_busy(sel), 1);
    for (int k = 0; k < 9 + nstop; k++) begin
      e = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : 1'b1;
      for (int c = 0; c < 4; c++) begin
        check($sformatf("%s.bit%0d", tag, k), cur_tx(sel), e);
        step();
      end
    end
    check({tag, ".busy_end"}, cur_busy(sel), 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) step();
    check("rst.tx", tx, 1);
    check("rst.busy", busy, 0);
    check("rst.ready", req_ready, 0);
    check("rst.gid", grant_id, 0);
    check("rst.lock_err", lock_err, 0);
    check("rst.tx2", tx2, 1);
    rst_n = 1'b1;
    step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int n;
    int err_at, rdy_at, err_cnt, both;
    logic [N-1:0] rdy_val;
    logic [1:0]   gid_at_err;
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    req_valid2 = '0;
    req_data2  = '0;
    req_last2  = '0;

    // 1: single byte A5 from requester 0
    apply_reset();
    req_q[0].push_back({1'b1, 8'hA5});
    step();
    check("t1.ready", req_ready, 4'b0001);
    check("t1.gid", grant_id, 0);
    step();
    check("t1.ready_off", req_ready, 4'b0000);
    frame(0, 8'hA5, 2'd0, 1, -1, "t1");

    // 2: all four valid -> strict rotation, back-to-back frames
    apply_reset();
    req_q[0].push_back({1'b1, 8'h11});
    req_q[0].push_back({1'b1, 8'h11});
    req_q[1].push_back({1'b1, 8'h22});
    req_q[2].push_back({1'b1, 8'h33});
    req_q[3].push_back({1'b1, 8'h44});
    frame(0, 8'h11, 2'd0, 1, -1, "t2a");
    frame(0, 8'h22, 2'd1, 1, 4, "t2b");
    frame(0, 8'h33, 2'd2, 1, 4, "t2c");
    frame(0, 8'h44, 2'd3, 1, 4, "t2d");
    frame(0, 8'h11, 2'd0, 1, 4, "t2e");

    // 3: packet of three from requester 1 stays atomic against requester 2
    req_q[1].push_back({1'b0, 8'hB1});
    req_q[1].push_back({1'b0, 8'hB2});
    req_q[1].push_back({1'b1, 8'hB3});
    req_q[2].push_back({1'b1, 8'hC2});
    frame(0, 8'hB1, 2'd1, 1, -1, "t3a");
    frame(0, 8'hB2, 2'd1, 1, 4, "t3b");
    frame(0, 8'hB3, 2'd1, 1, 4, "t3c");
    frame(0, 8'hC2, 2'd2, 1, 4, "t3d");

    // 4: requester 1 locks then goes idle; requester 0 waits for the timeout
    req_q[1].push_back({1'b0, 8'hD1});
    step();
    step();
    req_q[0].push_back({1'b1, 8'hE0});
    frame(0, 8'hD1, 2'd1, 1, -1, "t4a");
    err_at = -1; rdy_at = -1; err_cnt = 0; both = 0;
    rdy_val = '0; gid_at_err = '0;
    for (int i = 0; i < 300 && rdy_at < 0; i++) begin
      if (lock_err) begin
        err_cnt++;
        if (err_at < 0) begin
          err_at = i;
          gid_at_err = grant_id;
        end
      end
      if (req_ready != 0 && lock_err) both++;
      if (req_ready != 0) begin
        rdy_at  = i;
        rdy_val = req_ready;
      end
      step();
    end
    // IDLE is entered on the STOP tick; 32 further ticks at 4 CLKs each.
    check("t4.err_at", err_at, 128);
    check("t4.rdy_at", rdy_at, 129);
    check("t4.err_cnt", err_cnt, 1);
    check("t4.overlap", both, 0);
    check("t4.rdy_val", rdy_val, 4'b0001);
    check("t4.gid_hold", gid_at_err, 1);
    check("t4.err_off", lock_err, 0);
    frame(0, 8'hE0, 2'd0, 1, 2, "t4b");

    // 5: reset during data bit 4, then requester 0 has priority again
    req_q[2].push_back({1'b1, 8'h5A});
    wait_start(0, n);
    repeat (22) step();
    rst_n = 1'b0;
    #1;
    check("t5.tx", tx, 1);
    check("t5.busy", busy, 0);
    check("t5.ready", req_ready, 0);
    check("t5.gid", grant_id, 0);
    req_q[0].push_back({1'b1, 8'h3C});
    req_q[3].push_back({1'b1, 8'h7E});
    repeat (3) step();
    rst_n = 1'b1;
    n = 0;
    while (req_ready == 0 && n < 20) begin
      step();
      n++;
    end
    check("t5.lat", n, 1);
    check("t5.ready_after", req_ready, 4'b0001);
    frame(0, 8'h3C, 2'd0, 1, -1, "t5a");
    frame(0, 8'h7E, 2'd3, 1, 4, "t5b");

    // 6: two stop bits -> 8 high CLKs after bit 7, busy drops 44 CLKs in
    req_valid2 = 4'b0001;
    req_data2  = 32'h0000_0096;
    req_last2  = 4'b0001;
    n = 0;
    while (req_ready2 == 0 && n < 20) begin
      step();
      n++;
    end
    check("t6.lat", n, 1);
    check("t6.ready", req_ready2, 4'b0001);
    step();
    req_valid2 = '0;
    frame(1, 8'h96, 2'd0, 2, -1, "t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
